wb_port_arbiter: RTL and testbench

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_port_arbiter_pkg.sv | 19 +
 rtl/wb_fifo.sv | 90 +++++++++
 rtl/wb_port_arbiter.sv | 106 ++++++++++
 tb/tb_wb_port_arbiter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and widths for the register-file write-port arbiter.
package wb_port_arbiter_pkg;

    localparam int REG_IDX_W = 5;
    localparam int DATA_W    = 32;

    // One buffered register write.
    typedef struct packed {
        logic [REG_IDX_W-1:0] rd;
        logic [DATA_W-1:0]    data;
        logic                 valid;
    } wb_entry_t;

    // x0 is hard-wired, so writes that target it are never real writes.
    function automatic logic isRealRd(input logic [REG_IDX_W-1:0] rd);
        return rd != '0;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small circular holding buffer for ALU writes that lost the write port.
// Exposes its head and a per-entry register-match vector for two queries.
module wb_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 push,
    input  logic [REG_IDX_W-1:0] pushRd,
    input  logic [DATA_W-1:0]    pushData,
    input  logic                 pop,
    output logic                 full,
    output logic                 empty,
    output logic [REG_IDX_W-1:0] headRd,
    output logic [DATA_W-1:0]    headData,
    input  logic [REG_IDX_W-1:0] queryA,
    input  logic [REG_IDX_W-1:0] queryB,
    output logic [DEPTH-1:0]     matchA,
    output logic [DEPTH-1:0]     matchB
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    wb_entry_t        entries [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [CNT_W-1:0] count;
    logic             pushOk;
    logic             popOk;

    assign full   = (count == FULL_CNT);
    assign empty  = (count == '0);
    // Guards keep the count inside 0..DEPTH even if a caller misbehaves.
    assign pushOk = push && !full;
    assign popOk  = pop && !empty;

    assign headRd   = entries[rdPtr].rd;
    assign headData = entries[rdPtr].data;

    // Pointer and occupancy bookkeeping; pointers wrap at DEPTH, not at 2**PTR_W.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (pushOk) begin
                wrPtr <= (wrPtr == LAST_PTR) ? '0 : wrPtr + 1'b1;
            end
            if (popOk) begin
                rdPtr <= (rdPtr == LAST_PTR) ? '0 : rdPtr + 1'b1;
            end
            case ({pushOk, popOk})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; a popped slot is invalidated so it stops matching queries.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            if (popOk) begin
                entries[rdPtr].valid <= 1'b0;
            end
            if (pushOk) begin
                entries[wrPtr] <= '{rd: pushRd, data: pushData, valid: 1'b1};
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_match
            assign matchA[gi] = entries[gi].valid && (entries[gi].rd == queryA);
            assign matchB[gi] = entries[gi].valid && (entries[gi].rd == queryB);
        end
    endgenerate

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: load data first, then buffered ALU
// writes, then a direct ALU bypass. Losing ALU writes are parked in wb_fifo.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 alu_valid,
    input  logic [REG_IDX_W-1:0] alu_rd,
    input  logic [DATA_W-1:0]    alu_data,
    input  logic                 mem_valid,
    input  logic [REG_IDX_W-1:0] mem_rd,
    input  logic [DATA_W-1:0]    mem_data,
    input  logic [REG_IDX_W-1:0] rs1,
    input  logic [REG_IDX_W-1:0] rs2,
    output logic                 stall,
    output logic                 wr_en,
    output logic [REG_IDX_W-1:0] wr_rd,
    output logic [DATA_W-1:0]    wr_data,
    output logic                 rs1_busy,
    output logic                 rs2_busy
);

    logic                 fifoFull;
    logic                 fifoEmpty;
    logic [REG_IDX_W-1:0] headRd;
    logic [DATA_W-1:0]    headData;
    logic [DEPTH-1:0]     matchA;
    logic [DEPTH-1:0]     matchB;

    logic                 memReq;
    logic                 aluReq;
    logic                 headWin;
    logic                 aluBypass;
    logic                 fifoPush;
    logic                 wrEnNext;
    logic [REG_IDX_W-1:0] wrRdNext;
    logic [DATA_W-1:0]    wrDataNext;

    // Requests to x0 are treated as absent: they never occupy the port or the buffer.
    assign memReq    = mem_valid && isRealRd(mem_rd);
    assign aluReq    = alu_valid && !stall && isRealRd(alu_rd);
    assign headWin   = !memReq && !fifoEmpty;
    assign aluBypass = aluReq && fifoEmpty && !memReq;
    assign fifoPush  = aluReq && !aluBypass;
    assign stall     = fifoFull;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (fifoPush),
        .pushRd   (alu_rd),
        .pushData (alu_data),
        .pop      (headWin),
        .full     (fifoFull),
        .empty    (fifoEmpty),
        .headRd   (headRd),
        .headData (headData),
        .queryA   (rs1),
        .queryB   (rs2),
        .matchA   (matchA),
        .matchB   (matchB)
    );

    // Fixed-priority selection of the write for the next edge; idle keeps address/data.
    always_comb begin
        wrEnNext   = 1'b0;
        wrRdNext   = wr_rd;
        wrDataNext = wr_data;
        if (memReq) begin
            wrEnNext   = 1'b1;
            wrRdNext   = mem_rd;
            wrDataNext = mem_data;
        end else if (headWin) begin
            wrEnNext   = 1'b1;
            wrRdNext   = headRd;
            wrDataNext = headData;
        end else if (aluBypass) begin
            wrEnNext   = 1'b1;
            wrRdNext   = alu_rd;
            wrDataNext = alu_data;
        end
    end

    // Registered register-file write port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_en   <= 1'b0;
            wr_rd   <= '0;
            wr_data <= '0;
        end else begin
            wr_en   <= wrEnNext;
            wr_rd   <= wrRdNext;
            wr_data <= wrDataNext;
        end
    end

    // A source register is busy while a write to it is buffered or on the port.
    always_comb begin
        rs1_busy = isRealRd(rs1) && ((|matchA) || (wr_en && (wr_rd == rs1)));
        rs2_busy = isRealRd(rs2) && ((|matchB) || (wr_en && (wr_rd == rs2)));
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic, all checked
// against a queue-based model of the arbitration rules.
module tb_wb_port_arbiter;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_data = '0;
    logic        mem_valid = 1'b0;
    logic [4:0]  mem_rd = '0;
    logic [31:0] mem_data = '0;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic        stall;
    logic        wr_en;
    logic [4:0]  wr_rd;
    logic [31:0] wr_data;
    logic        rs1_busy;
    logic        rs2_busy;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    // Reference state: pending ALU writes in arrival order, and the expected port.
    wr_t         modelQ[$];
    logic        expEn = 1'b0;
    logic [4:0]  expRd = '0;
    logic [31:0] expData = '0;

    always #5 clk = ~clk;

    wb_port_arbiter #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .mem_valid (mem_valid),
        .mem_rd    (mem_rd),
        .mem_data  (mem_data),
        .rs1       (rs1),
        .rs2       (rs2),
        .stall     (stall),
        .wr_en     (wr_en),
        .wr_rd     (wr_rd),
        .wr_data   (wr_data),
        .rs1_busy  (rs1_busy),
        .rs2_busy  (rs2_busy)
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic modelBusy(input logic [4:0] rs);
        if (rs == 0) return 1'b0;
        if (expEn && expRd == rs) return 1'b1;
        foreach (modelQ[i]) if (modelQ[i].rd == rs) return 1'b1;
        return 1'b0;
    endfunction

    // One clock: drive inputs, check outputs against the model, advance the model at the edge.
    task automatic cycle(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] mdat,
                         input logic [4:0] q1, input logic [4:0] q2);
        bit memGo;
        bit aluGo;
        @(negedge clk);
        alu_valid = av; alu_rd = ard; alu_data = adat;
        mem_valid = mv; mem_rd = mrd; mem_data = mdat;
        rs1 = q1; rs2 = q2;
        #1;
        checkVal("stall", stall, (modelQ.size() == DEPTH));
        checkVal("wr_en", wr_en, expEn);
        checkVal("wr_rd", wr_rd, expRd);
        checkVal("wr_data", wr_data, expData);
        checkVal("rs1_busy", rs1_busy, modelBusy(q1));
        checkVal("rs2_busy", rs2_busy, modelBusy(q2));
        $display("cyc=%0d alu=%0b/%0d/%0h mem=%0b/%0d/%0h stall=%0b wr=%0b/%0d/%0h pend=%0d",
                 cyc, av, ard, adat, mv, mrd, mdat, stall, wr_en, wr_rd, wr_data, modelQ.size());
        memGo = mv && (mrd != 0);
        aluGo = av && (ard != 0) && (modelQ.size() < DEPTH);
        if (memGo) begin
            expEn = 1'b1; expRd = mrd; expData = mdat;
            if (aluGo) modelQ.push_back('{ard, adat});
        end else if (modelQ.size() > 0) begin
            wr_t h;
            h = modelQ.pop_front();
            expEn = 1'b1; expRd = h.rd; expData = h.data;
            if (aluGo) modelQ.push_back('{ard, adat});
        end else if (aluGo) begin
            expEn = 1'b1; expRd = ard; expData = adat;
        end else begin
            expEn = 1'b0;
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic idle(input int n, input logic [4:0] q1, input logic [4:0] q2);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, q1, q2);
    endtask

    task automatic resetPulse();
        @(negedge clk);
        alu_valid = 0; mem_valid = 1; mem_rd = 9; mem_data = 32'hDEAD;
        reset_n = 0;
        #1;
        checkVal("rst_wr_en", wr_en, 1'b0);
        checkVal("rst_wr_rd", wr_rd, 5'd0);
        checkVal("rst_wr_data", wr_data, 32'd0);
        checkVal("rst_stall", stall, 1'b0);
        checkVal("rst_busy1", rs1_busy, 1'b0);
        checkVal("rst_busy2", rs2_busy, 1'b0);
        modelQ.delete();
        expEn = 0; expRd = 0; expData = 0;
        @(posedge clk);
        @(negedge clk);
        mem_valid = 0;
        reset_n = 1;
    endtask

    initial begin
        rs1 = 5'd1; rs2 = 5'd2;
        #2;
        resetPulse();

        // Lone ALU write goes straight through the bypass.
        cycle(1, 5, 32'h11, 0, 0, 0, 5, 0);
        idle(2, 5, 5);

        // Collision: load first, buffered ALU write one cycle later.
        cycle(1, 4, 32'hBB, 1, 3, 32'hAA, 3, 4);
        idle(3, 3, 4);

        // Fill the buffer, hold an ALU request under stall, then drain.
        cycle(1, 1, 32'h101, 1, 2, 32'h202, 1, 2);
        cycle(1, 3, 32'h303, 1, 4, 32'h404, 1, 3);
        cycle(1, 5, 32'h505, 1, 6, 32'h606, 5, 1);
        cycle(1, 5, 32'h505, 0, 0, 0, 5, 3);
        cycle(1, 5, 32'h505, 0, 0, 0, 5, 3);
        idle(4, 5, 3);

        // Same destination: load value then ALU value land on x7.
        cycle(1, 7, 32'd2, 1, 7, 32'd1, 7, 0);
        idle(3, 7, 7);

        // Writes to x0 vanish.
        cycle(1, 0, 32'h55, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 32'h66, 0, 0);
        cycle(1, 0, 32'h77, 1, 0, 32'h88, 0, 0);
        idle(2, 0, 0);

        // Reset with two buffered writes: none of them may appear afterwards.
        cycle(1, 10, 32'hA0, 1, 11, 32'hB0, 10, 12);
        cycle(1, 12, 32'hA1, 1, 13, 32'hB1, 10, 12);
        resetPulse();
        idle(4, 10, 12);

        // Random traffic with a small register range to force collisions.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)), $urandom,
                  ($urandom_range(0, 99) < 45), 5'($urandom_range(0, 7)), $urandom,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            if (i == 300) resetPulse();
        end
        idle(4, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog: the run is cycle-bounded, this only guards against a stuck clock loop.
    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
        $fatal(1, "timeout");
    end

endmodule
